seq_priority_encoder: RTL and testbench

SEQ_PRIORITY_ENCODER -- requirements
Module: seq_priority_encoder

---
 rtl/pe_pkg.sv | 11 +
 rtl/pe_search.sv | 46 ++++
 rtl/seq_priority_encoder.sv | 82 ++++++++
 tb/tb_seq_priority_encoder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and limits for the sequential priority encoder.
package pe_pkg;

  localparam int PE_MAX_N = 64;

  typedef enum logic {
    PE_FIXED = 1'b0,  // bit 0 always wins
    PE_RR    = 1'b1   // search starts at a rotating pointer
  } pe_mode_e;

endpackage

// File: rtl/pe_search.sv
// Combinational circular search: the first set bit of vec at or above start,
// wrapping past N-1 to 0. Also flags an empty vector and two or more bits set.
module pe_search #(
  parameter int N = 10,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic [W-1:0] index,
  output logic         found,
  output logic         multi
);

  localparam logic [W:0] N_EXT = (W+1)'(N);

  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;
  logic [W-1:0]   offset;
  logic [W:0]     sum;
  logic [W:0]     wrapped;

  // Rotating right by start puts bit 'start' at position 0 of the view.
  assign doubled = {vec, vec} >> start;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
      assign rotated[gi] = doubled[gi];
    end
  endgenerate

  always_comb begin
    offset = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) offset = W'(i);
    end
  end

  assign sum     = {1'b0, start} + {1'b0, offset};
  assign wrapped = (sum >= N_EXT) ? (sum - N_EXT) : sum;

  assign found = |vec;
  // Clearing the lowest set bit leaves something only when two or more were set.
  assign multi = |(vec & (vec - N'(1)));
  assign index = found ? wrapped[W-1:0] : '0;

endmodule

// File: rtl/seq_priority_encoder.sv
// Registered priority encoder with a one-deep valid/ready output stage and
// optional round-robin start pointer.
module seq_priority_encoder
  import pe_pkg::*;
#(
  parameter int       N    = 10,
  parameter pe_mode_e MODE = PE_FIXED,
  localparam int      W    = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] q,
  output logic         none,
  output logic         multi
);

  generate
    if (N < 2 || N > PE_MAX_N) begin : g_bad_n
      $error("seq_priority_encoder: N out of range");
    end
  endgenerate

  logic         out_valid_reg;
  logic [W-1:0] q_reg;
  logic         none_reg;
  logic         multi_reg;
  logic [W-1:0] ptr_reg;

  logic [W-1:0] start;
  logic [W-1:0] hit_index;
  logic         hit_found;
  logic         hit_multi;
  logic [W-1:0] ptr_next;
  logic         accept;

  assign start = (MODE == PE_RR) ? ptr_reg : '0;

  pe_search #(
    .N(N),
    .W(W)
  ) u_search (
    .vec  (d),
    .start(start),
    .index(hit_index),
    .found(hit_found),
    .multi(hit_multi)
  );

  assign in_ready = !rst && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;
  assign ptr_next = (hit_index == W'(N - 1)) ? '0 : hit_index + W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      q_reg         <= '0;
      none_reg      <= 1'b0;
      multi_reg     <= 1'b0;
      ptr_reg       <= '0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      q_reg         <= hit_index;
      none_reg      <= !hit_found;
      multi_reg     <= hit_multi;
      // An empty vector grants nothing, so the pointer stays put.
      if (MODE == PE_RR && hit_found) ptr_reg <= ptr_next;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign q         = q_reg;
  assign none      = none_reg;
  assign multi     = multi_reg;

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Drives a FIXED and an RR encoder with the same stimulus and checks both
// against a reference model every cycle, plus hand-computed spot values.
module tb_seq_priority_encoder;
  import pe_pkg::*;

  localparam int N = 10;
  localparam int W = $clog2(N);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [N-1:0] d = '0;
  logic         out_ready = 1'b1;

  logic         fx_in_ready, fx_out_valid, fx_none, fx_multi;
  logic [W-1:0] fx_q;
  logic         rr_in_ready, rr_out_valid, rr_none, rr_multi;
  logic [W-1:0] rr_q;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  seq_priority_encoder #(.N(N), .MODE(PE_FIXED)) dut_fx (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(fx_in_ready), .d(d),
    .out_valid(fx_out_valid), .out_ready(out_ready), .q(fx_q), .none(fx_none),
    .multi(fx_multi)
  );

  seq_priority_encoder #(.N(N), .MODE(PE_RR)) dut_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rr_in_ready), .d(d),
    .out_valid(rr_out_valid), .out_ready(out_ready), .q(rr_q), .none(rr_none),
    .multi(rr_multi)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: index 0 = fixed priority, index 1 = round robin.
  bit valid_m [2];
  int q_m     [2];
  bit none_m  [2];
  bit multi_m [2];
  int ptr_m   [2];

  function automatic int grant(input bit rr, input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = rr ? (p + k) % N : k;
      if (v[idx]) return idx;
    end
    return 0;
  endfunction

  function automatic bit ready_m(input int m);
    return !rst && (!valid_m[m] || out_ready);
  endfunction

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        valid_m[m] <= 1'b0; q_m[m] <= 0; none_m[m] <= 1'b0;
        multi_m[m] <= 1'b0; ptr_m[m] <= 0;
      end else if (in_valid && ready_m(m)) begin
        int ones;
        int g;
        ones = $countones(d);
        g = grant(m == 1, d, ptr_m[m]);
        valid_m[m] <= 1'b1;
        q_m[m]     <= g;
        none_m[m]  <= (ones == 0);
        multi_m[m] <= (ones >= 2);
        if (m == 1 && ones != 0) ptr_m[m] <= (g + 1) % N;
      end else if (out_ready) begin
        valid_m[m] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("fx_in_ready", fx_in_ready, ready_m(0));
      chk("fx_out_valid", fx_out_valid, valid_m[0]);
      chk("fx_q", fx_q, q_m[0]);
      chk("fx_none", fx_none, none_m[0]);
      chk("fx_multi", fx_multi, multi_m[0]);
      chk("rr_in_ready", rr_in_ready, ready_m(1));
      chk("rr_out_valid", rr_out_valid, valid_m[1]);
      chk("rr_q", rr_q, q_m[1]);
      chk("rr_none", rr_none, none_m[1]);
      chk("rr_multi", rr_multi, multi_m[1]);
      chk("rr_ptr", dut_rr.ptr_reg, ptr_m[1]);
    end
  end

  task automatic drive(input logic r, input logic v, input logic [N-1:0] dv, input logic ordy);
    @(posedge clk);
    #2;
    rst = r; in_valid = v; d = dv; out_ready = ordy;
  endtask

  logic [N-1:0] mix_tbl [8] = '{10'h000, 10'h201, 10'h3FF, 10'h100, 10'h0A0,
                                10'h001, 10'h300, 10'h044};
  logic [N-1:0] one_hot;

  initial begin
    drive(1, 0, '0, 1);
    drive(1, 0, '0, 1);
    chk_en = 1'b1;

    // Reset state
    drive(0, 0, '0, 1);
    @(negedge clk);
    chk("rst_out_valid", fx_out_valid, 0);
    chk("rst_q", fx_q, 0);
    chk("rst_ptr", dut_rr.ptr_reg, 0);

    // One-hot walk, fixed priority, back to back
    for (int i = 0; i < N; i++) begin
      one_hot = '0;
      one_hot[i] = 1'b1;
      drive(0, 1, one_hot, 1);
      if (i > 0) begin
        @(negedge clk);
        chk("walk_q", fx_q, i - 1);
        chk("walk_valid", fx_out_valid, 1);
      end
    end
    drive(0, 0, '0, 1);
    @(negedge clk);
    chk("walk_last_q", fx_q, 9);
    chk("walk_last_multi", fx_multi, 0);

    // Fixed: two bits set, then empty
    drive(0, 1, 10'h201, 1);
    drive(0, 1, 10'h000, 1);
    @(negedge clk);
    chk("fx201_q", fx_q, 0);
    chk("fx201_multi", fx_multi, 1);
    drive(0, 0, '0, 1);
    @(negedge clk);
    chk("fx0_none", fx_none, 1);
    chk("fx0_q", fx_q, 0);

    // Round robin from a fresh pointer: 0x201 three times
    drive(1, 0, '0, 1);
    drive(0, 1, 10'h201, 1);
    drive(0, 1, 10'h201, 1);
    @(negedge clk);
    chk("rr1_q", rr_q, 0);
    chk("rr1_ptr", dut_rr.ptr_reg, 1);
    drive(0, 1, 10'h201, 1);
    @(negedge clk);
    chk("rr2_q", rr_q, 9);
    chk("rr2_ptr", dut_rr.ptr_reg, 0);
    drive(0, 0, '0, 1);
    @(negedge clk);
    chk("rr3_q", rr_q, 0);
    chk("rr3_ptr", dut_rr.ptr_reg, 1);

    // Backpressure for three cycles, then consume and reload together
    drive(0, 1, 10'h008, 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, '0, 0);
      @(negedge clk);
      chk("bp_q", fx_q, 3);
      chk("bp_in_ready", fx_in_ready, 0);
      chk("bp_valid", fx_out_valid, 1);
    end
    drive(0, 1, 10'h010, 1);
    @(negedge clk);
    chk("bp_reload_ready", fx_in_ready, 1);
    drive(0, 0, '0, 1);
    @(negedge clk);
    chk("bp_new_q", fx_q, 4);
    chk("bp_new_valid", fx_out_valid, 1);
    chk("mid_ptr5", dut_rr.ptr_reg, 5);

    // Reset pulse with a pending result and a request offered during reset
    drive(1, 1, 10'h3FF, 1);
    @(negedge clk);
    chk("rst_in_ready", rr_in_ready, 0);
    drive(0, 1, 10'h3FF, 1);
    @(negedge clk);
    chk("mid_rst_valid", rr_out_valid, 0);
    chk("mid_rst_ptr", dut_rr.ptr_reg, 0);
    drive(0, 0, '0, 1);
    @(negedge clk);
    chk("post_rst_q", rr_q, 0);
    chk("post_rst_multi", rr_multi, 1);

    // Round robin: empty vector keeps the pointer, then search wraps
    drive(0, 1, 10'h008, 1);
    drive(0, 1, 10'h000, 1);
    @(negedge clk);
    chk("rrz_pre_ptr", dut_rr.ptr_reg, 4);
    drive(0, 1, 10'h009, 1);
    @(negedge clk);
    chk("rrz_none", rr_none, 1);
    chk("rrz_q", rr_q, 0);
    chk("rrz_ptr_held", dut_rr.ptr_reg, 4);
    drive(0, 0, '0, 1);
    @(negedge clk);
    chk("rrwrap_q", rr_q, 0);
    chk("rrwrap_ptr", dut_rr.ptr_reg, 1);

    // Mixed traffic with gaps and stalls, checked by the model only
    for (int i = 0; i < 32; i++) begin
      drive(0, (i % 3) != 2, mix_tbl[i % 8], (i % 4) != 3);
    end
    drive(0, 0, '0, 1);
    drive(0, 0, '0, 1);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
